// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//
// Single-cycle 32-bit MIPS-subset core: program counter, 32x32 register file,
// main control decoder, ALU and next-PC selection. Instruction and data
// memories live outside this block. One instruction retires per clock.
//
// Supported: R-type add/sub/and/or/slt/jr, lw, sw, beq, addi, j, jal.
// Unknown opcodes behave as a NOP.
//
// Ports
//   clk            in   rising-edge clock for PC and register file
//   reset          in   synchronous, active-high; clears PC and all registers
//   instruction    in   32-bit instruction fetched at pc
//   read_data_mem  in   load data returned for address alu_result
//   pc             out  current program counter
//   read_data      out  register rs (ALU operand A, jr target)
//   store_data     out  register rt (sw data)
//   alu_result     out  ALU output / data memory address
//   zero           out  alu_result == 0
//   write_data     out  register write-back value
//   write_reg      out  register write-back destination
//   reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
//   pc_src, jump   out  decoded control signals
//   alu_op         out  ALU operation class (00 add, 01 sub, 10 funct)
// -----------------------------------------------------------------------------
module cpu_datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] read_data_mem,
   output logic [31:0] pc,
   output logic [31:0] read_data,
   output logic [31:0] store_data,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] write_data,
   output logic [4:0]  write_reg,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        alu_src,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        pc_src,
   output logic        jump,
   output logic [1:0]  alu_op
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_JAL   = 6'b000011,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] target26;

   assign opcode   = instruction[31:26];
   assign rs       = instruction[25:21];
   assign rt       = instruction[20:16];
   assign rd       = instruction[15:11];
   assign funct    = instruction[5:0];
   assign imm16    = instruction[15:0];
   assign target26 = instruction[25:0];

   // Architectural state
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] regs_q [32];

   // Decode internals
   logic        branch;
   logic        is_jal;
   logic        is_jr;
   logic        funct_valid;

   // Datapath internals
   logic signed [31:0] imm_sext;
   logic signed [31:0] alu_a;
   logic signed [31:0] alu_b;
   logic [31:0]        pc_plus4;
   logic [31:0]        branch_tgt;
   logic [31:0]        jump_tgt;

   // ---------------------------------------------------------------------------
   // Main control decoder
   // ---------------------------------------------------------------------------
   assign funct_valid = (funct == FN_ADD) || (funct == FN_SUB) ||
                        (funct == FN_AND) || (funct == FN_OR)  ||
                        (funct == FN_SLT);
   assign is_jr       = (opcode == OP_RTYPE) && (funct == FN_JR);

   always_comb begin
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      is_jal     = 1'b0;
      alu_op     = ALUOP_ADD;
      case (opcode)
         OP_RTYPE: begin
            reg_dst   = 1'b1;
            alu_op    = ALUOP_FUNCT;
            // jr and undefined funct codes must not disturb the register file
            reg_write = funct_valid;
         end
         OP_LW: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
         end
         OP_SW: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         OP_BEQ: begin
            branch = 1'b1;
            alu_op = ALUOP_SUB;
         end
         OP_ADDI: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
         end
         OP_J: begin
            jump = 1'b1;
         end
         OP_JAL: begin
            jump      = 1'b1;
            reg_write = 1'b1;
            is_jal    = 1'b1;
         end
         default: begin
            // unknown opcode: all controls stay low, PC simply advances
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register file read (combinational, r0 hard-wired to zero)
   // ---------------------------------------------------------------------------
   assign read_data  = (rs == 5'd0) ? 32'd0 : regs_q[rs];
   assign store_data = (rt == 5'd0) ? 32'd0 : regs_q[rt];

   // ---------------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------------
   assign imm_sext = {{16{imm16[15]}}, imm16};
   assign alu_a    = read_data;
   assign alu_b    = alu_src ? imm_sext : store_data;

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALUOP_ADD: alu_result = alu_a + alu_b;
         ALUOP_SUB: alu_result = alu_a - alu_b;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_result = alu_a + alu_b;
               FN_SUB:  alu_result = alu_a - alu_b;
               FN_AND:  alu_result = alu_a & alu_b;
               FN_OR:   alu_result = alu_a | alu_b;
               FN_SLT:  alu_result = {31'd0, (alu_a < alu_b)};
               default: alu_result = 32'd0;
            endcase
         end
         default: alu_result = 32'd0;
      endcase
   end

   assign zero = (alu_result == 32'd0);

   // ---------------------------------------------------------------------------
   // Write-back selection
   // ---------------------------------------------------------------------------
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      if (is_jal) begin
         write_reg  = 5'd31;
         write_data = pc_plus4;
      end else begin
         write_reg  = reg_dst ? rd : rt;
         write_data = mem_to_reg ? read_data_mem : alu_result;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-PC selection: jr > jump > taken branch > sequential
   // ---------------------------------------------------------------------------
   assign pc_src     = branch & zero;
   assign branch_tgt = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign jump_tgt   = {pc_plus4[31:28], target26, 2'b00};

   always_comb begin
      pc_d = pc_plus4;
      if (is_jr) begin
         pc_d = read_data;
      end else if (jump) begin
         pc_d = jump_tgt;
      end else if (pc_src) begin
         pc_d = branch_tgt;
      end
   end

   assign pc = pc_q;

   // ---------------------------------------------------------------------------
   // State update: reset wins over the in-flight instruction's write-back
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else begin
         pc_q <= pc_d;
         if (reg_write && (write_reg != 5'd0)) begin
            regs_q[write_reg] <= write_data;
         end
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//
// Runs a short hand-assembled program through the core. Each table entry holds
// the instruction, load data and the combinational outputs expected during
// that cycle; the expected next PC is queued when the instruction is driven
// and checked after the clock edge. Reset and mid-program reset are exercised
// by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] read_data_mem;
   logic [31:0] pc;
   logic [31:0] read_data;
   logic [31:0] store_data;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] write_data;
   logic [4:0]  write_reg;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        alu_src;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        pc_src;
   logic        jump;
   logic [1:0]  alu_op;

   cpu_datapath dut (
      .clk          (clk),
      .reset        (reset),
      .instruction  (instruction),
      .read_data_mem(read_data_mem),
      .pc           (pc),
      .read_data    (read_data),
      .store_data   (store_data),
      .alu_result   (alu_result),
      .zero         (zero),
      .write_data   (write_data),
      .write_reg    (write_reg),
      .reg_write    (reg_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .alu_src      (alu_src),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .pc_src       (pc_src),
      .jump         (jump),
      .alu_op       (alu_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
      $fatal(1, "watchdog expired");
   end

   // ctrl packing: {reg_write, mem_read, mem_write, alu_src, reg_dst,
   //                mem_to_reg, pc_src, jump, alu_op[1:0]}
   typedef struct {
      logic [31:0] instr;
      logic [31:0] rdm;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] sd;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [9:0]  ctrl;
      logic        zero;
      logic [31:0] next;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   logic [31:0] exp_q [$];
   int checks;
   int failures;

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rdm,
                               input logic [31:0] pc_v, input logic [31:0] alu,
                               input logic [31:0] rd, input logic [31:0] sd,
                               input logic [31:0] wd, input logic [4:0] wr,
                               input logic [9:0] ctrl, input logic zr,
                               input logic [31:0] next);
      vec_t v;
      v.instr = instr; v.rdm = rdm; v.pc = pc_v; v.alu = alu;
      v.rd = rd; v.sd = sd; v.wd = wd; v.wr = wr;
      v.ctrl = ctrl; v.zero = zr; v.next = next;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, expv);
      end
   endtask

   function automatic logic [9:0] ctrl_now();
      return {reg_write, mem_read, mem_write, alu_src, reg_dst,
              mem_to_reg, pc_src, jump, alu_op};
   endfunction

   // Pops the expected PC queued for this edge and compares it.
   task automatic pop_pc(input string name);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: actual=%h required=<queued pc, queue empty>", name, pc);
      end else begin
         e = exp_q.pop_front();
         if (pc !== e) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, pc, e);
         end
      end
   endtask

   localparam logic [9:0] C_RTYPE = 10'b1000100010;
   localparam logic [9:0] C_NOWR  = 10'b0000100010;
   localparam logic [9:0] C_ADDI  = 10'b1001000000;
   localparam logic [9:0] C_JAL   = 10'b1000000100;
   localparam logic [9:0] C_J     = 10'b0000000100;
   localparam logic [9:0] C_BEQT  = 10'b0000001001;
   localparam logic [9:0] C_BEQN  = 10'b0000000001;
   localparam logic [9:0] C_SW    = 10'b0011000000;
   localparam logic [9:0] C_LW    = 10'b1101010000;
   localparam logic [31:0] D = 32'h12345678;

   initial begin
      checks   = 0;
      failures = 0;

      //            instr         rdm           pc     alu           rd            sd            wd            wr  ctrl     z  next
      vecs[0]  = mk(32'h0C000004, D,            32'h04, 32'h0,        32'h0,        32'h0,        32'h8,        31, C_JAL,   1, 32'h10); // jal
      vecs[1]  = mk(32'h20080007, D,            32'h10, 32'h7,        32'h0,        32'h0,        32'h7,        8,  C_ADDI,  0, 32'h14); // addi $8,$0,7
      vecs[2]  = mk(32'h01084020, D,            32'h14, 32'hE,        32'h7,        32'h7,        32'hE,        8,  C_RTYPE, 0, 32'h18); // add $8,$8,$8
      vecs[3]  = mk(32'h03E00008, D,            32'h18, 32'h0,        32'h8,        32'h0,        32'h0,        0,  C_NOWR,  1, 32'h08); // jr $31
      vecs[4]  = mk(32'h10000002, D,            32'h08, 32'h0,        32'h0,        32'h0,        32'h0,        0,  C_BEQT,  1, 32'h14); // beq taken
      vecs[5]  = mk(32'h00000005, D,            32'h14, 32'h0,        32'h0,        32'h0,        32'h0,        0,  C_NOWR,  1, 32'h18); // bad funct
      vecs[6]  = mk(32'hFC000000, D,            32'h18, 32'h0,        32'h0,        32'h0,        32'h0,        0,  10'b0,   1, 32'h1C); // unknown op
      vecs[7]  = mk(32'hAC080004, D,            32'h1C, 32'h4,        32'h0,        32'hE,        32'h4,        8,  C_SW,    0, 32'h20); // sw $8,4($0)
      vecs[8]  = mk(32'h8D09FFFC, 32'hDEADBEEF, 32'h20, 32'hA,        32'hE,        32'h0,        32'hDEADBEEF, 9,  C_LW,    0, 32'h24); // lw $9,-4($8)
      vecs[9]  = mk(32'h0128502A, D,            32'h24, 32'h1,        32'hDEADBEEF, 32'hE,        32'h1,        10, C_RTYPE, 0, 32'h28); // slt $10,$9,$8
      vecs[10] = mk(32'h01095822, D,            32'h28, 32'h2152411F, 32'hE,        32'hDEADBEEF, 32'h2152411F, 11, C_RTYPE, 0, 32'h2C); // sub $11,$8,$9
      vecs[11] = mk(32'h11090003, D,            32'h2C, 32'h2152411F, 32'hE,        32'hDEADBEEF, 32'h2152411F, 9,  C_BEQN,  0, 32'h30); // beq not taken
      vecs[12] = mk(32'h01096025, D,            32'h30, 32'hDEADBEEF, 32'hE,        32'hDEADBEEF, 32'hDEADBEEF, 12, C_RTYPE, 0, 32'h34); // or $12,$8,$9
      vecs[13] = mk(32'h01286824, D,            32'h34, 32'hE,        32'hDEADBEEF, 32'hE,        32'hE,        13, C_RTYPE, 0, 32'h38); // and $13,$9,$8
      vecs[14] = mk(32'h1000FFFE, D,            32'h38, 32'h0,        32'h0,        32'h0,        32'h0,        0,  C_BEQT,  1, 32'h34); // beq back -2
      vecs[15] = mk(32'h08000010, D,            32'h34, 32'h0,        32'h0,        32'h0,        32'h0,        0,  C_J,     1, 32'h40); // j 0x40
      vecs[16] = mk(32'h20000005, D,            32'h40, 32'h5,        32'h0,        32'h0,        32'h5,        0,  C_ADDI,  0, 32'h44); // addi $0,$0,5
      vecs[17] = mk(32'h00007020, D,            32'h44, 32'h0,        32'h0,        32'h0,        32'h0,        14, C_RTYPE, 1, 32'h48); // add $14,$0,$0

      // Reset: one edge with reset high
      reset         = 1'b1;
      instruction   = 32'h0;
      read_data_mem = 32'h0;
      @(posedge clk); #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_read_data", read_data, 32'h0);
      reset = 1'b0;
      #1;
      chk("nop_reg_write", {31'd0, reg_write}, 32'h0);
      exp_q.push_back(32'h4);
      @(posedge clk); #1;
      pop_pc("post_reset_pc");

      // Program table
      for (int i = 0; i < NVEC; i++) begin
         instruction   = vecs[i].instr;
         read_data_mem = vecs[i].rdm;
         #2;
         chk($sformatf("v%0d_pc", i),         pc,                    vecs[i].pc);
         chk($sformatf("v%0d_ctrl", i),       {22'd0, ctrl_now()},   {22'd0, vecs[i].ctrl});
         chk($sformatf("v%0d_alu_result", i), alu_result,            vecs[i].alu);
         chk($sformatf("v%0d_zero", i),       {31'd0, zero},         {31'd0, vecs[i].zero});
         chk($sformatf("v%0d_read_data", i),  read_data,             vecs[i].rd);
         chk($sformatf("v%0d_store_data", i), store_data,            vecs[i].sd);
         chk($sformatf("v%0d_write_data", i), write_data,            vecs[i].wd);
         chk($sformatf("v%0d_write_reg", i),  {27'd0, write_reg},    {27'd0, vecs[i].wr});
         exp_q.push_back(vecs[i].next);
         @(posedge clk); #1;
         pop_pc($sformatf("v%0d_next_pc", i));
      end

      // Mid-program reset: addi $8,$0,99 in flight while reset is high
      instruction = 32'h20080063;
      reset       = 1'b1;
      #2;
      chk("rst_decode_reg_write", {31'd0, reg_write}, 32'h1);
      chk("rst_decode_alu", alu_result, 32'd99);
      exp_q.push_back(32'h0);
      @(posedge clk); #1;
      pop_pc("midreset_pc");
      reset = 1'b0;
      // add $0,$8,$9 reads r8 and r9, both cleared by reset
      instruction = 32'h01090020;
      #2;
      chk("midreset_r8", read_data, 32'h0);
      chk("midreset_r9", store_data, 32'h0);
      exp_q.push_back(32'h4);
      @(posedge clk); #1;
      pop_pc("midreset_next_pc");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
